// File: rtl/matrix_column_scanner.sv
// matrix_column_scanner: scans five 7-bit column images onto a 5x7 LED
// matrix one column at a time, with a per-frame image snapshot.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   enable             1 = scan, 0 = matrix dark
//   column_4..column_0 image columns, pixel bit 0 = lit
//   row_lines          active-low row drive
//   column_select      one-hot active-high column select
//   frame_start        one-cycle pulse while the snapshot is taken
module matrix_column_scanner #(
   parameter int CLOCKS_PER_COLUMN = 50000,
   parameter int BLANK_CYCLES      = 16,
   parameter int COUNTER_WIDTH     = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [6:0] column_4,
   input  logic [6:0] column_3,
   input  logic [6:0] column_2,
   input  logic [6:0] column_1,
   input  logic [6:0] column_0,
   output logic [6:0] row_lines,
   output logic [4:0] column_select,
   output logic       frame_start
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      BLANK,
      DRIVE
   } state_t;

   localparam int CW = COUNTER_WIDTH;

   // Terminal counts of each phase; BLANK_LAST is unused when there is
   // no blanking because BLANK is then unreachable.
   localparam logic [CW-1:0] BLANK_LAST =
      CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [CW-1:0] DRIVE_LAST =
      CW'(CLOCKS_PER_COLUMN - BLANK_CYCLES - 1);

   // First phase of every column slot.
   localparam state_t SLOT_START =
      (BLANK_CYCLES > 0) ? BLANK : DRIVE;

   state_t          state, state_n;
   logic [2:0]      index, index_n;
   logic [CW-1:0]   count, count_n;
   logic [4:0][6:0] snap, snap_n;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         index <= 3'd4;
         count <= '0;
         snap  <= {5{7'h7F}};
      end else begin
         state <= state_n;
         index <= index_n;
         count <= count_n;
         snap  <= snap_n;
      end
   end

   always_comb begin
      state_n = state;
      index_n = index;
      count_n = count;
      snap_n  = snap;
      if (!enable) begin
         // Dropping enable parks the scanner; the image is kept.
         state_n = IDLE;
         index_n = 3'd4;
         count_n = '0;
      end else begin
         unique case (state)
            IDLE: begin
               state_n = LOAD;
            end
            LOAD: begin
               snap_n  = {column_4, column_3, column_2,
                          column_1, column_0};
               index_n = 3'd4;
               count_n = '0;
               state_n = SLOT_START;
            end
            BLANK: begin
               if (count == BLANK_LAST) begin
                  count_n = '0;
                  state_n = DRIVE;
               end else begin
                  count_n = count + CW'(1);
               end
            end
            DRIVE: begin
               if (count == DRIVE_LAST) begin
                  count_n = '0;
                  if (index == 3'd0) begin
                     state_n = LOAD;
                  end else begin
                     index_n = index - 3'd1;
                     state_n = SLOT_START;
                  end
               end else begin
                  count_n = count + CW'(1);
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   // Moore outputs: only registered state feeds the pins.
   always_comb begin
      row_lines     = 7'h7F;
      column_select = 5'b00000;
      frame_start   = (state == LOAD);
      if (state == DRIVE) begin
         column_select = 5'(1) << index;
         row_lines     = snap[index];
      end
   end

endmodule

// File: tb/tb_matrix_column_scanner.sv
// tb_matrix_column_scanner: table, directed and random checks of the
// column scanner with and without blanking against a frame-position model.
module tb_matrix_column_scanner;

   localparam int CPC   = 8;
   localparam int FRAME = 5 * CPC + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic [6:0] cols [5];
   logic [6:0] row_a, row_b;
   logic [4:0] sel_a, sel_b;
   logic       fs_a, fs_b;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   matrix_column_scanner #(
      .CLOCKS_PER_COLUMN(CPC),
      .BLANK_CYCLES(2),
      .COUNTER_WIDTH(16)
   ) dut_a (
      .clock(clk), .reset(rst), .enable(en),
      .column_4(cols[4]), .column_3(cols[3]),
      .column_2(cols[2]), .column_1(cols[1]),
      .column_0(cols[0]),
      .row_lines(row_a), .column_select(sel_a),
      .frame_start(fs_a)
   );

   matrix_column_scanner #(
      .CLOCKS_PER_COLUMN(CPC),
      .BLANK_CYCLES(0),
      .COUNTER_WIDTH(16)
   ) dut_b (
      .clock(clk), .reset(rst), .enable(en),
      .column_4(cols[4]), .column_3(cols[3]),
      .column_2(cols[2]), .column_1(cols[1]),
      .column_0(cols[0]),
      .row_lines(row_b), .column_select(sel_b),
      .frame_start(fs_b)
   );

   // Model: position inside the frame, 0 = the snapshot cycle.
   int         blk [2] = '{2, 0};
   bit         m_act [2];
   int         m_pos [2];
   logic [6:0] m_snap [2][5];

   task automatic chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_clock();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_act[k] = 1'b0;
            for (int c = 0; c < 5; c++) m_snap[k][c] = 7'h7F;
         end else if (!m_act[k]) begin
            if (en) begin
               m_act[k] = 1'b1;
               m_pos[k] = 0;
            end
         end else if (!en) begin
            m_act[k] = 1'b0;
         end else begin
            if (m_pos[k] == 0)
               for (int c = 0; c < 5; c++) m_snap[k][c] = cols[c];
            m_pos[k] = (m_pos[k] + 1) % FRAME;
         end
      end
   endtask

   task automatic model_out(input int k, output logic [6:0] r,
                            output logic [4:0] s, output logic f);
      int p, col;
      r = 7'h7F;
      s = 5'b0;
      f = m_act[k] && m_pos[k] == 0;
      if (m_act[k] && m_pos[k] > 0) begin
         p = m_pos[k] - 1;
         col = 4 - p / CPC;
         if (p % CPC >= blk[k]) begin
            s = 5'(1) << col;
            r = m_snap[k][col];
         end
      end
   endtask

   task automatic step();
      logic [6:0] r;
      logic [4:0] s;
      logic f;
      @(posedge clk);
      model_clock();
      @(negedge clk);
      model_out(0, r, s, f);
      chk("a_rows", row_a, r);
      chk("a_sel", sel_a, s);
      chk("a_fs", fs_a, f);
      model_out(1, r, s, f);
      chk("b_rows", row_b, r);
      chk("b_sel", sel_b, s);
      chk("b_fs", fs_b, f);
   endtask

   task automatic run_to(input int target);
      int n = 0;
      while (!(m_act[0] && m_pos[0] == target) && n < 100) begin
         step();
         n++;
      end
      if (n >= 100) chk("run_to_timeout", n, 0);
   endtask

   task automatic set_pattern();
      cols[4] = 7'b1101111;
      cols[3] = 7'b1011111;
      cols[2] = 7'b0000000;
      cols[1] = 7'b1011111;
      cols[0] = 7'b1101111;
   endtask

   typedef struct {
      logic       rst;
      logic       en;
      logic [4:0] sel;
      logic [6:0] row;
      logic       fs;
      int         reps;
   } vec_t;

   vec_t tbl [14];

   initial begin
      int n;
      set_pattern();
      tbl[0]  = '{1, 1, 5'b00000, 7'h7F, 0, 2};
      tbl[1]  = '{0, 1, 5'b00000, 7'h7F, 1, 1};
      tbl[2]  = '{0, 1, 5'b00000, 7'h7F, 0, 2};
      tbl[3]  = '{0, 1, 5'b10000, 7'b1101111, 0, 6};
      tbl[4]  = '{0, 1, 5'b00000, 7'h7F, 0, 2};
      tbl[5]  = '{0, 1, 5'b01000, 7'b1011111, 0, 6};
      tbl[6]  = '{0, 1, 5'b00000, 7'h7F, 0, 2};
      tbl[7]  = '{0, 1, 5'b00100, 7'b0000000, 0, 6};
      tbl[8]  = '{0, 1, 5'b00000, 7'h7F, 0, 2};
      tbl[9]  = '{0, 1, 5'b00010, 7'b1011111, 0, 6};
      tbl[10] = '{0, 1, 5'b00000, 7'h7F, 0, 2};
      tbl[11] = '{0, 1, 5'b00001, 7'b1101111, 0, 6};
      tbl[12] = '{0, 1, 5'b00000, 7'h7F, 1, 1};
      tbl[13] = '{0, 1, 5'b00000, 7'h7F, 0, 2};

      // Reset, then one full frame into the next frame's blank.
      for (int i = 0; i < 14; i++) begin
         for (int j = 0; j < tbl[i].reps; j++) begin
            rst = tbl[i].rst;
            en = tbl[i].en;
            step();
            chk("tbl_sel", sel_a, tbl[i].sel);
            chk("tbl_rows", row_a, tbl[i].row);
            chk("tbl_fs", fs_a, tbl[i].fs);
         end
      end

      // Input changes mid-frame wait for the next snapshot.
      run_to(11);
      for (int c = 0; c < 5; c++) cols[c] = 7'h7F;
      run_to(19);
      chk("snap_old_sel", sel_a, 5'b00100);
      chk("snap_old_rows", row_a, 7'b0000000);
      run_to(0);
      run_to(3);
      chk("snap_new_sel", sel_a, 5'b10000);
      chk("snap_new_rows", row_a, 7'h7F);

      // Disable mid-column, then resume at column 4.
      set_pattern();
      run_to(0);
      run_to(19);
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("dis_sel", sel_a, 5'b0);
         chk("dis_rows", row_a, 7'h7F);
      end
      en = 1'b1;
      step();
      chk("reen_fs", fs_a, 1);
      run_to(3);
      chk("reen_sel", sel_a, 5'b10000);
      chk("reen_rows", row_a, 7'b1101111);

      // Synchronous reset pulse during column 1.
      run_to(27);
      rst = 1'b1;
      step();
      chk("rst_sel", sel_a, 5'b0);
      chk("rst_rows", row_a, 7'h7F);
      chk("rst_fs", fs_a, 0);
      rst = 1'b0;
      step();
      chk("rst_load_fs", fs_a, 1);
      run_to(3);
      chk("rst_frame_sel", sel_a, 5'b10000);

      // Frame length without blanking.
      n = 0;
      while (!fs_b && n < 100) begin
         step();
         n++;
      end
      chk("b_fs_seen", fs_b, 1);
      n = 0;
      do begin
         step();
         n++;
      end while (!fs_b && n < 100);
      chk("b_frame_len", n, FRAME);

      // Random traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         en = ($urandom_range(0, 49) != 0);
         for (int c = 0; c < 5; c++) cols[c] = 7'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/matrix_column_scanner.md
Name: matrix_column_scanner

Overview:
- Time-multiplexed driver for the 5x7 LED matrix.
- Consumes the five static 7-bit column images produced by the image selector and scans them onto the physical matrix one column at a time.
- Snapshots the image once per frame, so a state change mid-frame never tears the displayed picture.
- Inserts a blanking gap between columns to suppress ghosting.

Parameters:
- CLOCKS_PER_COLUMN, 50000: total clock cycles per column slot, blank plus drive. Must be > BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles at the start of each slot during which all columns are off. 0 is legal.
- COUNTER_WIDTH, 16: width of the slot cycle counter. Must satisfy 2^COUNTER_WIDTH >= CLOCKS_PER_COLUMN.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = scan the matrix, 0 = matrix dark.
- column_4  input  7  image column 4; pixel bit 0 = lit, 1 = off.
- column_3  input  7  image column 3; same encoding.
- column_2  input  7  image column 2; same encoding.
- column_1  input  7  image column 1; same encoding.
- column_0  input  7  image column 0; same encoding.
- row_lines  output  7  row drive, active-low; 0 = LED on.
- column_select  output  5  one-hot, active-high; bit k selects column k.
- frame_start  output  1  one-cycle pulse when a new frame snapshot is taken.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clock, reset). Reset overrides enable.
- Reset values:
  - state = IDLE, column index = 4, slot counter = 0.
  - Snapshot registers all 7'b1111111.
  - row_lines = 7'b1111111, column_select = 5'b00000, frame_start = 0.
- Outputs are Moore: decoded only from registered state, index and snapshot. There is no combinational path from any input to any output.
- State machine (IDLE, LOAD, BLANK, DRIVE):
  - IDLE: outputs off. If enable = 1 -> LOAD.
  - LOAD (exactly 1 cycle):
    - Register column_4..column_0 into the snapshot; set index = 4; set counter = 0.
    - frame_start = 1 in this cycle only; outputs off.
    - Next state: BLANK if BLANK_CYCLES > 0, else DRIVE.
  - BLANK:
    - Outputs off; counter increments each cycle.
    - After BLANK_CYCLES cycles in BLANK -> DRIVE with counter = 0.
  - DRIVE:
    - column_select = one-hot(index); row_lines = snapshot[index].
    - After CLOCKS_PER_COLUMN - BLANK_CYCLES cycles in DRIVE:
      - index = 0 -> LOAD (new frame).
      - else index decrements by 1 -> BLANK (or DRIVE if BLANK_CYCLES = 0), counter = 0.
- Scan order is 4, 3, 2, 1, 0.
- Frame length is 5 x CLOCKS_PER_COLUMN + 1 cycles (the extra cycle is LOAD).
- enable = 0 sampled in any non-IDLE state:
  - Next state is IDLE; outputs off from the following cycle.
  - Counter = 0, index = 4; snapshot retained.
  - Re-enable always restarts with LOAD at column 4.
- Input changes outside the LOAD cycle have no effect until the next LOAD.
- At most one bit of column_select is ever 1.
- column_select = 0 whenever row_lines = 7'b1111111 is forced, i.e. in all non-DRIVE states.
- Counter never exceeds CLOCKS_PER_COLUMN - 1; no wrap-around within a slot.

Test Plan (CLOCKS_PER_COLUMN = 8, BLANK_CYCLES = 2 unless noted):
1. Reset: assert reset for 2 cycles with enable = 1 -> row_lines = 7'b1111111, column_select = 0, frame_start = 0.
2. Full frame: release reset with enable = 1 and columns 4..0 = 1101111, 1011111, 0000000, 1011111, 1101111.
   - frame_start pulses one cycle.
   - 2 dark cycles, then 6 cycles of select = 10000 / rows = 1101111.
   - Then per column: 2 dark cycles and 6 drive cycles in order 01000 / 1011111, 00100 / 0000000, 00010 / 1011111, 00001 / 1101111.
   - Next frame_start occurs 41 cycles after the first.
3. Snapshot: during the column-3 drive, change all inputs to 7'b1111111 -> remaining columns still show the old pattern; the new blank pattern appears only after the next frame_start.
4. Disable: drop enable during the column-2 drive -> outputs off the next cycle and stay off. Re-assert enable -> frame_start next cycle, scan resumes at column 4.
5. Mid-frame reset: pulse reset for 1 cycle during the column-1 drive with enable = 1 -> all reset values the next cycle, then a LOAD cycle (frame_start = 1), then a normal frame.
6. No blanking: BLANK_CYCLES = 0 -> LOAD goes straight to DRIVE; each column is driven for exactly 8 consecutive cycles; frame length is 41 cycles.
